// File: rtl/rr_grant_sequencer_pkg.sv
// Shared types and sizes for the four-requester round-robin grant sequencer.
package rr_grant_sequencer_pkg;
   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;
endpackage

// File: rtl/rr_grant_sequencer_rr_pick4.sv
// Combinational rotate-priority picker: first set request bit at or after rr_ptr (mod 4).
module rr_pick4
   import rr_grant_sequencer_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [ADDR_W-1:0]  rr_ptr,
   output logic [ADDR_W-1:0]  sel_addr,
   output logic               sel_valid
);
   logic [ADDR_W-1:0] w_idx [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_idx
         assign w_idx[gi] = rr_ptr + ADDR_W'(gi);
      end
   endgenerate

   // Scan from lowest priority to highest so the nearest hit to rr_ptr wins.
   always_comb begin
      sel_addr  = rr_ptr;
      sel_valid = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[w_idx[k]]) begin
            sel_addr  = w_idx[k];
            sel_valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/rr_grant_sequencer.sv
// Round-robin grant sequencer with registered break-before-make decoder drive.
// Optional forced revocation after MAX_HOLD cycles: define RR_GRANT_TIMEOUT_EN.
module rr_grant_sequencer
   import rr_grant_sequencer_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = 8
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               release_i,
   output logic [ADDR_W-1:0]  grant_addr,
   output logic               grant_en,
   output logic               busy,
   output logic               timeout
);
   state_t            r_state, w_state_next;
   logic [ADDR_W-1:0] r_rr_ptr, w_rr_ptr_next;
   logic [ADDR_W-1:0] r_grant_addr, w_grant_addr_next;
   logic              r_grant_en, r_busy, r_timeout, w_timeout_next;
   logic [ADDR_W-1:0] w_sel_addr;
   logic              w_sel_valid;
   logic              w_exit, w_force;

   if (MAX_HOLD < 2 || MAX_HOLD > 255 || (MAX_HOLD >> HOLD_W) != 0) begin : g_bad_cfg
      $error("rr_grant_sequencer: MAX_HOLD/HOLD_W out of range");
   end

   rr_pick4 u_pick (
      .req       (req),
      .rr_ptr    (r_rr_ptr),
      .sel_addr  (w_sel_addr),
      .sel_valid (w_sel_valid)
   );

   // Release and withdrawal together are a single exit.
   assign w_exit = release_i | ~req[r_grant_addr];

`ifdef RR_GRANT_TIMEOUT_EN
   logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_next;

   assign w_force = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1)) & ~w_exit;

   always_comb begin
      w_hold_cnt_next = r_hold_cnt;
      if (r_state != GRANT)
         w_hold_cnt_next = '0;
      else if (!(&r_hold_cnt))
         w_hold_cnt_next = r_hold_cnt + HOLD_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_hold_cnt <= '0;
      else
         r_hold_cnt <= w_hold_cnt_next;
   end
`else
   assign w_force = 1'b0;
`endif

   always_comb begin
      w_state_next      = r_state;
      w_rr_ptr_next     = r_rr_ptr;
      w_grant_addr_next = r_grant_addr;
      w_timeout_next    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_sel_valid) begin
               w_state_next      = GRANT;
               w_grant_addr_next = w_sel_addr;
            end
         end
         GRANT: begin
            if (w_exit || w_force) begin
               w_state_next   = GAP;
               w_rr_ptr_next  = r_grant_addr + ADDR_W'(1);
               w_timeout_next = w_force;
            end
         end
         GAP:     w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they never glitch into the decoder.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_rr_ptr     <= '0;
         r_grant_addr <= '0;
         r_grant_en   <= 1'b0;
         r_busy       <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_rr_ptr     <= w_rr_ptr_next;
         r_grant_addr <= w_grant_addr_next;
         r_grant_en   <= (w_state_next == GRANT);
         r_busy       <= (w_state_next != IDLE);
         r_timeout    <= w_timeout_next;
      end
   end

   assign grant_addr = r_grant_addr;
   assign grant_en   = r_grant_en;
   assign busy       = r_busy;
   assign timeout    = r_timeout;
endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_rr_grant_sequencer;
   localparam int TB_MAX_HOLD = 4;
`ifdef RR_GRANT_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       release_i;
   logic [1:0] grant_addr;
   logic       grant_en;
   logic       busy;
   logic       timeout;
   logic [3:0] dec;

   int checks   = 0;
   int failures = 0;

   // model state: 0 idle, 1 granted, 2 gap
   int   m_state, m_ptr, m_addr, m_hold;
   logic m_to;

   rr_grant_sequencer #(.MAX_HOLD(TB_MAX_HOLD), .HOLD_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .release_i  (release_i),
      .grant_addr (grant_addr),
      .grant_en   (grant_en),
      .busy       (busy),
      .timeout    (timeout)
   );

   // downstream 2-to-4 structural decoder
   assign dec[0] = grant_en & ~grant_addr[1] & ~grant_addr[0];
   assign dec[1] = grant_en & ~grant_addr[1] &  grant_addr[0];
   assign dec[2] = grant_en &  grant_addr[1] & ~grant_addr[0];
   assign dec[3] = grant_en &  grant_addr[1] &  grant_addr[0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   task automatic model_reset();
      m_state = 0; m_ptr = 0; m_addr = 0; m_hold = 0; m_to = 1'b0;
   endtask

   task automatic model_update(input logic [3:0] r, input logic rl);
      m_to = 1'b0;
      case (m_state)
         0: if (r != 4'b0000) begin
               m_addr  = pick(r, m_ptr);
               m_state = 1;
               m_hold  = 0;
            end
         1: if (rl || !r[m_addr]) begin
               m_state = 2;
               m_ptr   = (m_addr + 1) % 4;
            end else if (TO_EN && m_hold == TB_MAX_HOLD - 1) begin
               m_state = 2;
               m_ptr   = (m_addr + 1) % 4;
               m_to    = 1'b1;
            end else begin
               m_hold++;
            end
         default: m_state = 0;
      endcase
   endtask

   task automatic check_all();
      logic [3:0] exp_dec;
      exp_dec = (m_state == 1) ? 4'(1 << m_addr) : 4'b0000;
      chk("grant_en", 8'(grant_en), 8'(m_state == 1));
      chk("grant_addr", 8'(grant_addr), 8'(m_addr));
      chk("busy", 8'(busy), 8'(m_state != 0));
      chk("timeout", 8'(timeout), 8'(m_to));
      chk("decoder", 8'(dec), 8'(exp_dec));
   endtask

   task automatic step(input logic [3:0] r, input logic rl);
      req = r;
      release_i = rl;
      @(posedge clk);
      model_update(r, rl);
      #1;
      check_all();
      $display("step req=%b rel=%b -> en=%b addr=%0d busy=%b to=%b dec=%b",
               r, rl, grant_en, grant_addr, busy, timeout, dec);
   endtask

   initial begin
      int rr_order [5];
      logic [3:0] rnd_req;
      rr_order = '{0, 1, 2, 3, 0};
      rst_n = 1'b0; req = 4'b0000; release_i = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      chk("reset_en", 8'(grant_en), 8'd0);
      rst_n = 1'b1;

      // round robin with every requester active
      for (int g = 0; g < 5; g++) begin
         step(4'b1111, 1'b0);
         chk("rr_order", 8'(grant_addr), 8'(rr_order[g]));
         step(4'b1111, 1'b1);
         step(4'b1111, 1'b0);
      end

      // single request
      step(4'b0100, 1'b0);
      chk("single_addr", 8'(grant_addr), 8'd2);
      chk("single_dec", 8'(dec), 8'b0000_0100);
      step(4'b0100, 1'b1);
      step(4'b0000, 1'b0);

      // wrap: pointer now 3
      step(4'b0011, 1'b0);
      chk("wrap_first", 8'(grant_addr), 8'd0);
      step(4'b0011, 1'b1);
      step(4'b0011, 1'b0);
      step(4'b0011, 1'b0);
      chk("wrap_second", 8'(grant_addr), 8'd1);

      // withdraw of requester 1 while granted
      step(4'b1101, 1'b0);
      chk("withdraw_gap", 8'(grant_en), 8'd0);
      step(4'b1111, 1'b0);
      step(4'b1111, 1'b0);
      chk("withdraw_ptr", 8'(grant_addr), 8'd2);
      step(4'b1111, 1'b1);
      step(4'b0000, 1'b0);

      // asynchronous reset in the middle of a grant
      step(4'b1000, 1'b0);
      chk("pre_reset_addr", 8'(grant_addr), 8'd3);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("async_reset_busy", 8'(busy), 8'd0);
      req = 4'b0000;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // held request never released
      step(4'b0001, 1'b0);
      for (int c = 0; c < TB_MAX_HOLD; c++) step(4'b0001, 1'b0);
`ifdef RR_GRANT_TIMEOUT_EN
      chk("timeout_pulse", 8'(timeout), 8'd1);
      step(4'b0001, 1'b0);
      chk("timeout_clear", 8'(timeout), 8'd0);
      step(4'b0001, 1'b0);
      chk("timeout_regrant", 8'(grant_addr), 8'd0);
`endif
      step(4'b0001, 1'b1);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);

      // random traffic; requests change occasionally so grants get held for a while
      rnd_req = 4'b0000;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) rnd_req = 4'($urandom_range(0, 15));
         step(rnd_req, 1'($urandom_range(0, 4) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rr_grant_sequencer.md
Name: rr_grant_sequencer

Overview:
- Round-robin arbiter and grant sequencer for four requesters. It produces the 2-bit address plus enable that drive the 2-to-4 structural decoder directly downstream; the decoder's one-hot outputs become the per-requester grant lines.
- Fully registered outputs with break-before-make sequencing, so decoder outputs never overlap between grants even with gate delays present.

Parameters:
- MAX_HOLD, 16: maximum cycles one grant may be held (used only with the optional feature); legal range 2..255.
- HOLD_W, 8: width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  single system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request vector; bit i = requester i; level-sensitive.
- release_i  input  1  current grant holder finished; sampled only in GRANT.
- grant_addr  output  2  encoded index of granted requester; feeds decoder address1:address0.
- grant_en  output  1  grant valid; feeds decoder enable.
- busy  output  1  high in GRANT or GAP.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled externally):
  - grant_addr=2'b00, grant_en=0, busy=0, timeout=0.
  - state=IDLE, rr_ptr=0, hold_cnt=0.
- States: IDLE, GRANT, GAP.
- IDLE:
  - grant_en=0.
  - If req!=0, select the first set bit searching rr_ptr, rr_ptr+1, ... (mod 4).
  - Next edge: grant_addr=selected, grant_en=1, state=GRANT, hold_cnt=0.
  - If req==0, remain in IDLE; grant_addr holds its last value.
- GRANT:
  - grant_en=1; grant_addr is stable for the entire state.
  - Exit to GAP when release_i=1 OR req[grant_addr]=0 (requester withdrew).
  - On exit: rr_ptr <= grant_addr+1 (2-bit wrap, 3->0), grant_en <= 0.
  - Otherwise hold_cnt increments each cycle, saturating at all-ones.
- GAP:
  - Exactly one cycle with grant_en=0, busy=1; grant_addr unchanged; then IDLE.
- Latency:
  - req to grant_en is 1 cycle from IDLE.
  - Back-to-back grants: minimum 2 idle-enable cycles between successive grants (GAP + IDLE arbitration cycle).
- Fairness: the holder of the just-ended grant has lowest priority next round; starvation-free when every grant ends.
- Simultaneous events:
  - release_i together with req[grant_addr] drop counts as one exit.
  - release_i outside GRANT is ignored.
- Mid-operation reset: all outputs go to reset values immediately, without waiting for a clock; the in-flight grant is lost, not resumed.
- Width rules: rr_ptr and grant_addr are 2-bit modulo arithmetic; no other arithmetic.

Optional Feature:
- Macro: RR_GRANT_TIMEOUT_EN.
- Defined:
  - In GRANT, when hold_cnt == MAX_HOLD-1 and no release/withdraw occurs that cycle, force exit to GAP.
  - timeout=1 for exactly the GAP cycle; rr_ptr advances as for a normal exit.
  - Release and timeout in the same cycle counts as a normal release, timeout=0.
- Undefined: no forced exit, timeout tied 0, hold_cnt logic may be removed; MAX_HOLD unused.

Decomposition:
- Shared package:
  - state enum (IDLE=2'd0, GRANT=2'd1, GAP=2'd2).
  - NUM_REQ=4.
  - ADDR_W=2.
- Sub-module rr_pick4: combinational rotate-priority picker (req, rr_ptr -> sel_addr, sel_valid).
- Sequencer FSM, counter and output registers live in the top module.
- Bench instantiates the structural decoder downstream to check one-hot grants.

Test Plan:
- Reset: rst_n=0 mid-GRANT with grant_en=1 -> grant_en=0, grant_addr=0, busy=0 before next clk edge.
- Single request: req=4'b0100 from IDLE -> next cycle grant_addr=2, grant_en=1; decoder out2 only; release_i pulse -> GAP 1 cycle, then IDLE.
- Round-robin: req=4'b1111 held, release_i pulsed each GRANT -> grant order 0,1,2,3,0; grant_en low for 2 cycles between each.
- Wrap/priority: rr_ptr=3, req=4'b0011 -> grant_addr=0; after release, req=4'b0011 -> grant_addr=1.
- Withdraw: in GRANT for addr 1, drop req[1] with release_i=0 -> GAP next cycle, rr_ptr=2.
- Timeout (RR_GRANT_TIMEOUT_EN, MAX_HOLD=4): req=4'b0001, never release -> grant_en high exactly 4 cycles, timeout pulse 1 cycle, regrant to 0 after IDLE.
